// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code set 2 decoder.
package ps2_pkg;

  localparam logic [7:0] B_E0     = 8'hE0;
  localparam logic [7:0] B_F0     = 8'hF0;
  localparam logic [7:0] B_E1     = 8'hE1;
  localparam logic [7:0] B_FA     = 8'hFA;
  localparam logic [7:0] B_AA     = 8'hAA;
  localparam logic [7:0] B_EE     = 8'hEE;
  localparam logic [7:0] B_FE     = 8'hFE;
  localparam logic [7:0] B_00     = 8'h00;
  localparam logic [7:0] B_FF     = 8'hFF;
  localparam logic [7:0] B_LSHIFT = 8'h12;
  localparam logic [7:0] B_RSHIFT = 8'h59;

  // Bytes that follow E1 in the Pause sequence
  localparam logic [3:0] PAUSE_SKIP = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } state_t;

  typedef struct packed {
    logic       shift;
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_event_t;

  // Keyboard status/acknowledge bytes that never describe a key
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == B_FA) || (b == B_AA) || (b == B_EE) ||
           (b == B_FE) || (b == B_00) || (b == B_FF);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == B_E0) || (b == B_F0);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous first-word-fall-through FIFO for decoded key events.
module ps2_event_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees a slot in the same edge, so a full FIFO still accepts a push
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Scan-code set 2 byte stream to key events: prefix FSM, shift tracking,
// sticky error flags and an event FIFO toward the consumer.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_err,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic       ev_shift,
  output logic       shift_held,
  output logic [7:0] last_make,
  output logic       overflow,
  output logic       rx_error
);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_skip_cnt;
  logic       r_shift_l;
  logic       r_shift_r;
  logic [7:0] r_last_make;
  logic       r_overflow;
  logic       r_rx_error;
  logic       w_byte_ok;
  logic       w_emit;
  logic       w_ext;
  logic       w_rel;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  key_event_t w_event;
  key_event_t w_head;

  assign w_byte_ok = in_valid && !in_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (in_valid && in_err) begin
      w_next_state = ST_IDLE;
    end else if (in_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (in_data == B_E0)      w_next_state = ST_EXT;
          else if (in_data == B_F0) w_next_state = ST_BRK;
          else if (in_data == B_E1) w_next_state = ST_SKIP;
          else                      w_next_state = ST_IDLE;
        end
        ST_EXT: begin
          if (in_data == B_F0)      w_next_state = ST_EXT_BRK;
          else if (in_data == B_E0) w_next_state = ST_EXT;
          else                      w_next_state = ST_IDLE;
        end
        ST_SKIP: begin
          if (r_skip_cnt <= 4'd1) w_next_state = ST_IDLE;
          else                    w_next_state = ST_SKIP;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  always_comb begin
    w_emit = 1'b0;
    w_ext  = 1'b0;
    w_rel  = 1'b0;
    if (w_byte_ok) begin
      case (r_state)
        ST_IDLE: begin
          w_emit = !is_prefix(in_data) && (in_data != B_E1) && !is_status_byte(in_data);
        end
        ST_EXT: begin
          w_emit = !is_prefix(in_data);
          w_ext  = 1'b1;
        end
        ST_BRK: begin
          w_emit = !is_prefix(in_data);
          w_rel  = 1'b1;
        end
        ST_EXT_BRK: begin
          w_emit = !is_prefix(in_data);
          w_ext  = 1'b1;
          w_rel  = 1'b1;
        end
        default: begin
          w_emit = 1'b0;
        end
      endcase
    end else begin
      w_emit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_skip_cnt <= 4'd0;
    end else if (in_valid) begin
      if (in_err)                                         r_skip_cnt <= 4'd0;
      else if (r_state == ST_IDLE && in_data == B_E1)     r_skip_cnt <= PAUSE_SKIP;
      else if (r_state == ST_SKIP && r_skip_cnt != 4'd0)  r_skip_cnt <= r_skip_cnt - 4'd1;
      else                                                r_skip_cnt <= r_skip_cnt;
    end else begin
      r_skip_cnt <= r_skip_cnt;
    end
  end

  // Shift state and last_make follow every event, even one the FIFO drops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift_l   <= 1'b0;
      r_shift_r   <= 1'b0;
      r_last_make <= 8'h00;
    end else if (w_emit) begin
      if (!w_ext && in_data == B_LSHIFT) r_shift_l <= !w_rel;
      if (!w_ext && in_data == B_RSHIFT) r_shift_r <= !w_rel;
      if (!w_rel) r_last_make <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_rx_error <= 1'b0;
    end else begin
      r_overflow <= r_overflow || (w_emit && w_full && !w_pop);
      r_rx_error <= r_rx_error || (in_valid && in_err);
    end
  end

  assign w_event = '{shift: shift_held, ext: w_ext, rel: w_rel, code: in_data};
  assign w_pop   = !w_empty && ev_ready;

  ps2_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      ($bits(key_event_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_emit),
    .i_wdata (w_event),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign ev_valid   = !w_empty;
  assign ev_code    = w_head.code;
  assign ev_ext     = w_head.ext;
  assign ev_release = w_head.rel;
  assign ev_shift   = w_head.shift;
  assign shift_held = r_shift_l || r_shift_r;
  assign last_make  = r_last_make;
  assign overflow   = r_overflow;
  assign rx_error   = r_rx_error;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench: directed vector table, hand sequences for FIFO/reset
// corners, and random byte streams against a queue-based reference model.
module tb_ps2_scan_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_err;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_release;
  logic       ev_shift;
  logic       shift_held;
  logic [7:0] last_make;
  logic       overflow;
  logic       rx_error;

  int checks   = 0;
  int failures = 0;

  ps2_scan_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_err     (in_err),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_release (ev_release),
    .ev_shift   (ev_shift),
    .shift_held (shift_held),
    .last_make  (last_make),
    .overflow   (overflow),
    .rx_error   (rx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       ev;
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       sh;
    logic       held;
    logic [7:0] lm;
  } vec_t;

  vec_t vecs[$];

  // Reference model: pending-prefix flags, skip budget and a queue of events
  bit          model_on;
  bit          m_ext_pend, m_brk_pend;
  int          m_skip;
  logic [10:0] mq[$];
  bit          m_sl, m_sr, m_ovf, m_rxe;
  logic [7:0]  m_lm;

  function automatic vec_t mk(input logic [7:0] d, input logic ev, input logic [7:0] code,
                              input logic ext, input logic rel, input logic sh,
                              input logic held, input logic [7:0] lm);
    vec_t v;
    v.data = d; v.ev = ev; v.code = code; v.ext = ext; v.rel = rel;
    v.sh = sh; v.held = held; v.lm = lm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ext_pend = 1'b0; m_brk_pend = 1'b0; m_skip = 0;
    mq.delete();
    m_sl = 1'b0; m_sr = 1'b0; m_ovf = 1'b0; m_rxe = 1'b0; m_lm = 8'h00;
  endfunction

  function automatic void model_step(input logic v, input logic e, input logic [7:0] d,
                                     input logic r);
    bit pop, emit, ext, rel;
    pop = r && (mq.size() > 0);
    emit = 1'b0; ext = 1'b0; rel = 1'b0;
    if (v) begin
      if (e) begin
        m_rxe = 1'b1; m_ext_pend = 1'b0; m_brk_pend = 1'b0; m_skip = 0;
      end else if (m_skip > 0) begin
        m_skip--;
      end else if (m_brk_pend) begin
        if (d != 8'hE0 && d != 8'hF0) begin emit = 1'b1; ext = m_ext_pend; rel = 1'b1; end
        m_ext_pend = 1'b0; m_brk_pend = 1'b0;
      end else if (m_ext_pend) begin
        if (d == 8'hF0) m_brk_pend = 1'b1;
        else if (d != 8'hE0) begin emit = 1'b1; ext = 1'b1; m_ext_pend = 1'b0; end
      end else if (d == 8'hE0) m_ext_pend = 1'b1;
      else if (d == 8'hF0) m_brk_pend = 1'b1;
      else if (d == 8'hE1) m_skip = 7;
      else if (!(d inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) emit = 1'b1;
    end
    if (pop) void'(mq.pop_front());
    if (emit) begin
      if (mq.size() < DEPTH) mq.push_back({m_sl | m_sr, ext, rel, d});
      else m_ovf = 1'b1;
      if (!rel) m_lm = d;
      if (!ext && d == 8'h12) m_sl = !rel;
      if (!ext && d == 8'h59) m_sr = !rel;
    end
  endfunction

  task automatic cyc(input logic v, input logic e, input logic [7:0] d, input logic r);
    in_valid = v; in_err = e; in_data = d; ev_ready = r;
    if (model_on) model_step(v, e, d, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_err = 1'b0; in_data = 8'h00; ev_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic [7:0] code, input logic ext,
                          input logic rel);
    chk({name, "_valid"}, ev_valid, 1'b1);
    chk({name, "_code"}, ev_code, code);
    chk({name, "_ext_rel"}, {ev_ext, ev_release}, {ext, rel});
  endtask

  initial begin
    logic [7:0] pool [12];
    logic [7:0] pause [8];
    logic [7:0] exp_heads [3];
    logic [7:0] d;

    model_on = 1'b0;
    do_reset();
    chk("reset_ev_valid", ev_valid, 1'b0);
    chk("reset_ev_fields", {ev_code, ev_ext, ev_release, ev_shift}, 11'd0);
    chk("reset_flags", {shift_held, overflow, rx_error}, 3'b000);
    chk("reset_last_make", last_make, 8'h00);

    // Directed table, consumer always ready
    vecs.push_back(mk(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C));
    vecs.push_back(mk(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C));
    vecs.push_back(mk(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C));
    vecs.push_back(mk(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C));
    vecs.push_back(mk(8'h75, 1'b1, 8'h75, 1'b1, 1'b0, 1'b0, 1'b0, 8'h75));
    vecs.push_back(mk(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h75));
    vecs.push_back(mk(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h75));
    vecs.push_back(mk(8'h75, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0, 8'h75));
    vecs.push_back(mk(8'h12, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12));
    vecs.push_back(mk(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1C));
    vecs.push_back(mk(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C));
    vecs.push_back(mk(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b1, 1'b1, 8'h1C));
    vecs.push_back(mk(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C));
    vecs.push_back(mk(8'h12, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C));
    pause = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    foreach (pause[i]) vecs.push_back(mk(pause[i], 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C));
    vecs.push_back(mk(8'h29, 1'b1, 8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 8'h29));
    vecs.push_back(mk(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h29));
    vecs.push_back(mk(8'h12, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12));
    vecs.push_back(mk(8'hFA, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12));
    vecs.push_back(mk(8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12));
    vecs.push_back(mk(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12));
    vecs.push_back(mk(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12));
    vecs.push_back(mk(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C));

    foreach (vecs[i]) begin
      cyc(1'b1, 1'b0, vecs[i].data, 1'b1);
      chk($sformatf("vec%0d_ev_valid", i), ev_valid, vecs[i].ev);
      if (vecs[i].ev)
        chk($sformatf("vec%0d_event", i), {ev_code, ev_ext, ev_release, ev_shift},
            {vecs[i].code, vecs[i].ext, vecs[i].rel, vecs[i].sh});
      chk($sformatf("vec%0d_shift_held", i), shift_held, vecs[i].held);
      chk($sformatf("vec%0d_last_make", i), last_make, vecs[i].lm);
    end

    // FIFO fill, push+pop while full, drop on overflow, drain in order
    do_reset();
    cyc(1'b1, 1'b0, 8'h15, 1'b0);
    cyc(1'b1, 1'b0, 8'h16, 1'b0);
    cyc(1'b1, 1'b0, 8'h17, 1'b0);
    cyc(1'b1, 1'b0, 8'h18, 1'b0);
    chk_head("full_head", 8'h15, 1'b0, 1'b0);
    chk("full_no_ovf", overflow, 1'b0);
    cyc(1'b1, 1'b0, 8'h20, 1'b1);
    chk_head("pushpop_head", 8'h16, 1'b0, 1'b0);
    chk("pushpop_no_ovf", overflow, 1'b0);
    cyc(1'b1, 1'b0, 8'h19, 1'b0);
    chk("drop_ovf", overflow, 1'b1);
    chk("drop_last_make", last_make, 8'h19);
    chk_head("stall_head", 8'h16, 1'b0, 1'b0);
    exp_heads = '{8'h17, 8'h18, 8'h20};
    foreach (exp_heads[i]) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk_head($sformatf("drain%0d", i), exp_heads[i], 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("drain_empty", ev_valid, 1'b0);
    cyc(1'b1, 1'b1, 8'hE0, 1'b0);
    chk("err_rx_error", rx_error, 1'b1);
    chk("err_no_event", ev_valid, 1'b0);
    cyc(1'b1, 1'b0, 8'h1C, 1'b0);
    chk_head("after_err", 8'h1C, 1'b0, 1'b0);
    chk("ovf_sticky", {overflow, rx_error}, 2'b11);

    // Reset mid-sequence discards the pending prefixes
    cyc(1'b1, 1'b0, 8'hE0, 1'b1);
    cyc(1'b1, 1'b0, 8'hF0, 1'b1);
    do_reset();
    chk("rst_empty", ev_valid, 1'b0);
    chk("rst_flags", {overflow, rx_error}, 2'b00);
    cyc(1'b1, 1'b0, 8'h1C, 1'b1);
    chk_head("rst_then_1c", 8'h1C, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rst_single_event", ev_valid, 1'b0);

    // Random streams against the reference model
    pool = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h1C, 8'hFA, 8'h00,
             8'h14, 8'h77, 8'h75, 8'hFF};
    model_on = 1'b1;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n == 750) do_reset();
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 11)];
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 40) == 0, d, $urandom_range(0, 1) == 1);
      chk("rnd_ev_valid", ev_valid, mq.size() > 0);
      if (mq.size() > 0)
        chk("rnd_head", {ev_shift, ev_ext, ev_release, ev_code}, mq[0]);
      chk("rnd_shift_held", shift_held, m_sl | m_sr);
      chk("rnd_last_make", last_make, m_lm);
      chk("rnd_sticky", {overflow, rx_error}, {m_ovf, m_rxe});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Consumes the PS/2 scan-code set 2 byte stream produced by the PS/2 receive stage and turns it into discrete key events: make/break, extended (E0) flag, and shift state. Events are queued in a small FIFO behind a valid/ready handshake for the consumer (LED driver, console logic). The most recent make code is also held for direct LED display. Runs entirely in the system clock domain; the upstream receiver delivers one-cycle byte strobes already synchronised to `clk`.

## Interface
- FIFO_DEPTH, 4, event FIFO depth; power of two, ≥2
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  one-cycle strobe: new byte on in_data
- in_data  in  8  received scan-code byte
- in_err  in  1  parity/framing error for this byte; qualified by in_valid
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts head when ev_valid & ev_ready
- ev_code  out  8  event scan code (prefixes stripped)
- ev_ext  out  1  code was E0-prefixed
- ev_release  out  1  break event (F0 seen)
- ev_shift  out  1  shift_held value before this event was applied
- shift_held  out  1  left or right shift currently held
- last_make  out  8  code of the most recent make event
- overflow  out  1  sticky: an event was dropped because FIFO full
- rx_error  out  1  sticky: a byte arrived with in_err

## Operation
- Reset values: ev_valid 0, ev_code/ev_ext/ev_release/ev_shift 0, shift_held 0, last_make 8'h00, overflow 0, rx_error 0; FSM IDLE; FIFO empty; skip counter 0.
- Bytes are processed only on in_valid; in_data is ignored otherwise.
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP.
  - IDLE: E0→EXT; F0→BRK; E1→SKIP with counter=7; FA, AA, EE, FE, 00, FF dropped, stay IDLE; any other byte→emit make {ext=0}, stay IDLE.
  - EXT: F0→EXT_BRK; E0 stays EXT; any other byte→emit make {ext=1}, →IDLE.
  - BRK: any byte other than E0/F0→emit break {ext=0}, →IDLE; E0 or F0 → IDLE, no event (malformed).
  - EXT_BRK: any byte other than E0/F0→emit break {ext=1}, →IDLE; E0 or F0 → IDLE, no event.
  - SKIP: each byte decrements the counter; the byte taking it to 0 returns to IDLE. Pause sequence (E1 14 77 E1 F0 14 F0 77) yields no events.
- in_err with in_valid: byte discarded, FSM→IDLE, skip counter cleared, rx_error set. No event.
- Shift tracking: non-extended code 8'h12 (left) or 8'h59 (right). Make sets the corresponding bit; break clears it. shift_held = OR of both bits. Extended 12/59 (E0 12 fake-shift) does not affect shift.
- ev_shift captures shift_held before the event's own update (shift make reports 0; shift break reports 1).
- last_make updates on every make event (ext or not), independent of FIFO space.
- Typematic repeats are not filtered: each repeated make is a separate event.
- Emit = push 11-bit {shift, ext, release, code} into FIFO. If full and no pop this cycle, drop and set overflow. Shift state and last_make still update on dropped events.
- overflow and rx_error clear only on rst.

## Timing
- Byte completing an event accepted at edge N; event written at edge N; ev_valid high after edge N if FIFO was empty (first-word-fall-through, 1-cycle latency). last_make and shift_held change after edge N.
- Pop on ev_valid & ev_ready at edge M; next entry or ev_valid=0 visible after M.
- Push and pop same edge when full: both take effect, no overflow. When empty, push and pop are not simultaneous (ev_valid is 0).
- ev_* outputs stable while ev_valid & !ev_ready.
- in_valid may assert on consecutive cycles; one byte processed per cycle, no back-pressure to upstream.
- rst on any edge overrides everything: FIFO flushed, FSM IDLE, mid-sequence prefixes discarded.

## Structure
- Package ps2_pkg: byte constants (E0, F0, E1, FA, AA, EE, FE, LSHIFT 8'h12, RSHIFT 8'h59), FSM state enum, key-event struct {shift, ext, release, code[7:0]}.
- Sub-module ps2_event_fifo: synchronous FWFT FIFO, parameter FIFO_DEPTH, 11-bit entries, full/empty, sync reset. Decoder FSM, shift tracking and sticky flags live in the top.

## Test plan
- Bytes 1C, F0 1C with ev_ready=1 → events {code 1C, ext 0, rel 0}, then {1C, 0, 1}; last_make=1C.
- E0 75, E0 F0 75 → {75, ext 1, rel 0}, {75, ext 1, rel 1}; shift_held stays 0.
- 12, 1C, F0 1C, F0 12 → ev_shift sequence 0,1,1,1; shift_held 1 after first byte, 0 after last.
- E1 14 77 E1 F0 14 F0 77 then 29 → only event {29, 0, 0}; FSM back in IDLE.
- ev_ready=0, send FIFO_DEPTH+1 makes (15,16,17,18,19) → first 4 retained in order, 19 dropped, overflow=1, last_make=19; then E0 with in_err → rx_error=1, next 1C decodes as non-extended.
- E0 F0, then rst for one cycle, then 1C → FIFO empty after reset; single event {1C, ext 0, rel 0}.
